traffic_phase_scheduler: RTL

Sequences a two-street intersection with optional pedestrian crossing: arbitrates green time between street A, street B and a latched pedestrian request, and drives the 3-bit lamp codes for each street. It is the demand-driven successor to the fixed-cycle light. It is instantiated at the top of the intersection controller, with sensors and push-button inputs already synchronised to `clk`.

---
 rtl/tls_pkg.sv | 18 +
 rtl/tls_phase_timer.sv | 43 ++++
 rtl/traffic_phase_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tls_pkg.sv
// rtl/tls_pkg.sv - lamp codes and phase encoding shared by the traffic scheduler
package tls_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    AR_A = 3'd0,
    G_A  = 3'd1,
    Y_A  = 3'd2,
    AR_B = 3'd3,
    G_B  = 3'd4,
    Y_B  = 3'd5,
    WALK = 3'd6
  } state_e;

endpackage

// File: rtl/tls_phase_timer.sv
// rtl/tls_phase_timer.sv - per-phase up-counter, cleared on state entry, saturating at GREEN_MAX-1
module tls_phase_timer #(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 20,
  parameter int GREEN_MAX = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] t_i,
  output logic             hit_min_o,
  output logic             hit_max_o,
  output logic             hit_t_o
);

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(GREEN_MAX - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != MAX_M1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_min_o = (cnt_q >= MIN_M1);
  assign hit_max_o = (cnt_q >= MAX_M1);
  assign hit_t_o   = (cnt_q == t_i - 1'b1);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - demand-driven two-street light; TLS_PED_EN adds the pedestrian walk phase
module traffic_phase_scheduler
  import tls_pkg::*;
#(
  parameter int GREEN_MIN = 20,
  parameter int GREEN_MAX = 60,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 15,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_a,
  input  logic       sensor_b,
  input  logic       ped_req,
  output logic [2:0] street_a,
  output logic [2:0] street_b,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  state_e           state_q, state_d;
  logic             next_b_q, next_b_d;
  logic             ped_pend_q;
  logic [2:0]       street_a_q, street_a_d;
  logic [2:0]       street_b_q, street_b_d;
  logic [CNT_W-1:0] t_sel;
  logic             hit_min, hit_max, hit_t;

  tls_phase_timer #(
    .CNT_W    (CNT_W),
    .GREEN_MIN(GREEN_MIN),
    .GREEN_MAX(GREEN_MAX)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_d != state_q),
    .t_i      (t_sel),
    .hit_min_o(hit_min),
    .hit_max_o(hit_max),
    .hit_t_o  (hit_t)
  );

  always_comb begin
    t_sel = CNT_W'(ALLRED_T);
    case (state_q)
      Y_A, Y_B: t_sel = CNT_W'(YELLOW_T);
      WALK:     t_sel = CNT_W'(WALK_T);
      default:  t_sel = CNT_W'(ALLRED_T);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    next_b_d = next_b_q;
    case (state_q)
      AR_A: if (hit_t) state_d = G_A;
      AR_B: if (hit_t) state_d = G_B;
      G_A:  if (hit_min && (sensor_b || ped_pend_q) && (!sensor_a || hit_max)) state_d = Y_A;
      G_B:  if (hit_min && (sensor_a || ped_pend_q) && (!sensor_b || hit_max)) state_d = Y_B;
      Y_A: begin
        if (hit_t) begin
          state_d  = ped_pend_q ? WALK : AR_B;
          next_b_d = 1'b1;
        end
      end
      Y_B: begin
        if (hit_t) begin
          state_d  = ped_pend_q ? WALK : AR_A;
          next_b_d = 1'b0;
        end
      end
      WALK:    if (hit_t) state_d = next_b_q ? AR_B : AR_A;
      default: state_d = AR_A;
    endcase
  end

  // Lamps are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    street_a_d = RED;
    street_b_d = RED;
    case (state_d)
      G_A:     street_a_d = GREEN;
      Y_A:     street_a_d = YELLOW;
      G_B:     street_b_d = GREEN;
      Y_B:     street_b_d = YELLOW;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= AR_A;
      next_b_q   <= 1'b0;
      street_a_q <= RED;
      street_b_q <= RED;
    end else begin
      state_q    <= state_d;
      next_b_q   <= next_b_d;
      street_a_q <= street_a_d;
      street_b_q <= street_b_d;
    end
  end

`ifdef TLS_PED_EN
  logic ped_pend_d;
  logic walk_q, ack_q;
  logic enter_walk;

  assign enter_walk = (state_d == WALK) && (state_q != WALK);

  // Entering WALK consumes the request; presses during WALK are dropped.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (enter_walk) begin
      ped_pend_d = 1'b0;
    end else if (ped_req && state_q != WALK) begin
      ped_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      walk_q     <= (state_d == WALK);
      ack_q      <= enter_walk;
    end
  end

  assign walk    = walk_q;
  assign ped_ack = ack_q;
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign ped_pend_q     = 1'b0;
  assign walk           = 1'b0;
  assign ped_ack        = 1'b0;
`endif

  assign street_a = street_a_q;
  assign street_b = street_b_q;
  assign phase    = state_q;

endmodule
